// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART serial transmitter.
//
// Accepts a parallel word over a valid/ready handshake and serialises it onto
// the line as: start bit (0), DATA_BITS data bits LSB first, an optional
// parity bit, then one stop bit (1). Each bit lasts CLKS_PER_BIT clocks. There
// is no free-running baud tick: the bit timer starts on the accept edge, so
// the start bit begins on the cycle immediately after the handshake.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (>= 2)
//   DATA_BITS     data bits per frame (5..8)
//   PARITY        0 = none, 1 = even, 2 = odd; any other value means none
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active high
//   data_i   in   word to transmit, sampled only on the accept cycle
//   valid_i  in   data_i valid
//   ready_o  out  a word can be accepted this cycle (registered)
//   data_o   out  serial line, idle high (registered)
//   busy_o   out  frame in progress, start through stop (registered)
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 data_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    // Only 1 and 2 enable a parity bit; every other value sends none.
    localparam logic PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam logic PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d,
                                         input logic                 odd);
        calc_parity = (^d) ^ odd;
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_s;
    logic                 parity_r;
    logic                 parity_s;
    logic                 line_r;
    logic                 line_s;
    logic                 ready_r;
    logic                 ready_s;
    logic                 busy_r;
    logic                 busy_s;
    logic                 bit_end_s;

    // Next-state logic. The output registers are loaded with the value that
    // belongs to the state being entered, so data_o/ready_o/busy_o change on
    // the same edge as the state and stay free of combinational glitches.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        shift_s   = shift_r;
        parity_s  = parity_r;
        line_s    = 1'b1;
        ready_s   = 1'b0;
        busy_s    = 1'b1;
        bit_end_s = (cnt_r == CNT_LAST);

        case (state_r)
            ST_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                idx_s = {IDX_W{1'b0}};
                // ready_r (not just the state) gates the accept, so the cycle
                // right after reset release can never take a word.
                if (valid_i && ready_r) begin
                    shift_s  = data_i;
                    parity_s = calc_parity(data_i, PAR_ODD);
                    state_s  = ST_START;
                    line_s   = 1'b0;
                    ready_s  = 1'b0;
                    busy_s   = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                    line_s   = 1'b1;
                    ready_s  = 1'b1;
                    busy_s   = 1'b0;
                end
            end

            ST_START: begin
                line_s = 1'b0;
                if (bit_end_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_DATA;
                    line_s  = shift_r[0];
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end

            ST_DATA: begin
                line_s = shift_r[0];
                if (bit_end_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (idx_r == IDX_LAST) begin
                        idx_s = {IDX_W{1'b0}};
                        if (PAR_EN) begin
                            state_s = ST_PARITY;
                            line_s  = parity_r;
                        end else begin
                            state_s = ST_STOP;
                            line_s  = 1'b1;
                        end
                    end else begin
                        idx_s  = idx_r + IDX_W'(1);
                        // Next data bit is the one about to shift into bit 0.
                        line_s = shift_r[1];
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            ST_PARITY: begin
                line_s = parity_r;
                if (bit_end_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_STOP;
                    line_s  = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end

            ST_STOP: begin
                line_s = 1'b1;
                if (bit_end_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_IDLE;
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                idx_s   = {IDX_W{1'b0}};
                line_s  = 1'b1;
                ready_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            shift_r  <= {DATA_BITS{1'b0}};
            parity_r <= 1'b0;
            line_r   <= 1'b1;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            shift_r  <= shift_s;
            parity_r <= parity_s;
            line_r   <= line_s;
            ready_r  <= ready_s;
            busy_r   <= busy_s;
        end
    end

    assign data_o  = line_r;
    assign ready_o = ready_r;
    assign busy_o  = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Three instances at CLKS_PER_BIT=4: dut0 without parity, dut1 even parity,
// dut2 odd parity. Accepted words are pushed to per-instance queues; a line
// monitor per instance detects each start bit, pops the expected word and
// checks every cycle of the frame against a bench-built bit pattern.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       valid0;
    logic       valid12;
    logic       rdy0, dout0, busy0;
    logic       rdy1, dout1, busy1;
    logic       rdy2, dout2, busy2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int         starts0[$];
    int         frames[3];
    logic       par_got[3];
    logic       mon_en0;

    always #5 clk = ~clk;

    // Cycle counter used to time frame starts.
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .data_i(din), .valid_i(valid0),
        .ready_o(rdy0), .data_o(dout0), .busy_o(busy0));

    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1)) dut1 (
        .clk(clk), .rst(rst), .data_i(din), .valid_i(valid12),
        .ready_o(rdy1), .data_o(dout1), .busy_o(busy1));

    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2)) dut2 (
        .clk(clk), .rst(rst), .data_i(din), .valid_i(valid12),
        .ready_o(rdy2), .data_o(dout2), .busy_o(busy2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic line_of(input int sel);
        case (sel)
            0:       return dout0;
            1:       return dout1;
            default: return dout2;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic rdy_of(input int sel);
        case (sel)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    // Expected line level for bit slot idx of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int par, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (par != 0 && idx == 9) return (par == 2) ? ~(^b) : (^b);
        return 1'b1;
    endfunction

    // Called on the first start-bit cycle; follows the frame to its last cycle.
    task automatic run_frame(input int sel);
        int         par;
        int         nbits;
        int         bad_line;
        int         bad_busy;
        logic [7:0] exp_b;
        logic [10:0] mid;
        logic       have;
        par      = sel;
        nbits    = (par != 0) ? 11 : 10;
        bad_line = 0;
        bad_busy = 0;
        exp_b    = 8'h00;
        mid      = 11'h000;
        have     = 1'b0;
        if (sel == 0) starts0.push_back(cyc);
        case (sel)
            0: if (q0.size() > 0) begin exp_b = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin exp_b = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin exp_b = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) check($sformatf("unexpected_frame%0d", sel), 32'd1, 32'd0);
        for (int i = 0; i < nbits * C; i++) begin
            if (i != 0) @(negedge clk);
            if (line_of(sel) !== exp_bit(exp_b, par, i / C)) bad_line++;
            if (busy_of(sel) !== 1'b1) bad_busy++;
            if (i % C == C / 2) mid[i / C] = line_of(sel);
        end
        check($sformatf("frame%0d_byte", sel), {24'd0, mid[8:1]}, {24'd0, exp_b});
        check($sformatf("frame%0d_shape", sel), bad_line, 32'd0);
        check($sformatf("frame%0d_busy", sel), bad_busy, 32'd0);
        check($sformatf("frame%0d_stop", sel), {31'd0, mid[nbits-1]}, 32'd1);
        if (par != 0) begin
            par_got[sel] = mid[9];
            check($sformatf("frame%0d_parity", sel), {31'd0, mid[9]},
                  {31'd0, exp_bit(exp_b, par, 9)});
        end
        frames[sel]++;
    endtask

    initial begin : mon_0
        forever begin
            @(negedge clk);
            if (mon_en0 && dout0 === 1'b0) run_frame(0);
        end
    end

    initial begin : mon_1
        forever begin
            @(negedge clk);
            if (dout1 === 1'b0) run_frame(1);
        end
    end

    initial begin : mon_2
        forever begin
            @(negedge clk);
            if (dout2 === 1'b0) run_frame(2);
        end
    end

    // Waits (bounded) for ready of one instance, sampled on negedges.
    task automatic wait_rdy(input int sel);
        int n;
        n = 0;
        while (rdy_of(sel) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rdy_of(sel) !== 1'b1) check($sformatf("ready_timeout%0d", sel), 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not end, n_errors %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] b2b[4];
        int         low;
        int         s0;
        int         bad;
        b2b = '{8'h5D, 8'hA5, 8'h00, 8'hFF};
        for (int i = 0; i < 3; i++) frames[i] = 0;
        rst     = 1'b1;
        din     = 8'h00;
        valid0  = 1'b0;
        valid12 = 1'b0;
        mon_en0 = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_data0", dout0, 1);
        check("rst_ready0", rdy0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_data1", dout1, 1);
        check("rst_ready2", rdy2, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst0", rdy0, 1);
        check("ready_after_rst1", rdy1, 1);

        // Single 0x5D, data_i changed right after the accept.
        wait_rdy(0);
        din = 8'h5D; valid0 = 1'b1; q0.push_back(8'h5D);
        @(negedge clk);
        valid0 = 1'b0; din = 8'hA3;
        check("busy_on_accept", busy0, 1);
        check("start_on_accept", dout0, 0);
        low = 0;
        while (rdy0 === 1'b0 && low < 200) begin low++; @(negedge clk); end
        check("ready_low_40", low, 40);

        // Back-to-back with valid_i held high.
        s0 = starts0.size();
        valid0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_rdy(0);
            din = b2b[k];
            q0.push_back(b2b[k]);
            @(negedge clk);
        end
        valid0 = 1'b0;
        wait_rdy(0);
        check("b2b_starts", starts0.size() - s0, 4);
        for (int k = 1; k < 4; k++) begin
            if (starts0.size() > s0 + k)
                check("b2b_stop_len", starts0[s0+k] - starts0[s0+k-1] - 9 * C, C + 1);
        end

        // Parity: 0x07 has three ones.
        wait_rdy(1);
        wait_rdy(2);
        din = 8'h07; valid12 = 1'b1; q1.push_back(8'h07); q2.push_back(8'h07);
        @(negedge clk);
        valid12 = 1'b0;
        low = 0;
        while (rdy1 === 1'b0 && low < 200) begin low++; @(negedge clk); end
        check("ready_low_44", low, 44);
        wait_rdy(2);
        check("par_even_07", par_got[1], 1);
        check("par_odd_07", par_got[2], 0);

        // Reset during data bit 3 of 0xFF (frame cycle 17).
        mon_en0 = 1'b0;
        wait_rdy(0);
        din = 8'hFF; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        repeat (17) @(negedge clk);
        check("mid_line", dout0, 1);
        check("mid_busy", busy0, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_data", dout0, 1);
        check("abort_busy", busy0, 0);
        check("abort_ready", rdy0, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_back", rdy0, 1);
        mon_en0 = 1'b1;

        // Clean frame after the abort, with a valid pulse while busy.
        din = 8'h3C; valid0 = 1'b1; q0.push_back(8'h3C);
        @(negedge clk);
        valid0 = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_not_ready", rdy0, 0);
        din = 8'h11; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        wait_rdy(0);

        // rst and valid_i together: rst wins.
        rst = 1'b1; valid0 = 1'b1; din = 8'h22;
        @(negedge clk);
        check("rst_valid_ready", rdy0, 0);
        check("rst_valid_line", dout0, 1);
        check("rst_valid_busy", busy0, 0);
        rst = 1'b0; valid0 = 1'b0;
        @(negedge clk);
        check("rst_valid_ready_back", rdy0, 1);

        // Long idle: line high, not busy.
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (dout0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_ready", rdy0, 1);

        check("frames0", frames[0], 6);
        check("frames1", frames[1], 1);
        check("frames2", frames[2], 1);
        check("q0_empty", q0.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
